frame_bank_ctrl: RTL and testbench

FRAME_BANK_CTRL -- requirements
Module: frame_bank_ctrl

---
 rtl/frame_bank_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_frame_bank_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/frame_bank_ctrl.sv
// Frame bank controller: rotates N_BANKS frame buffers between a raster-order
// pixel writer and a scaled VGA reader, so the display only switches frames
// at vsync and never shows a partially written frame.
module frame_bank_ctrl #(
   parameter int X_ADDRW     = 10,
   parameter int Y_ADDRW     = 9,
   parameter int SCALE_SHIFT = 2,
   parameter int H_SCALED    = 160,
   parameter int V_SCALED    = 120,
   parameter int N_BANKS     = 2,
   parameter int DATA_W      = 1,
   parameter int DROP_MODE   = 0,
   localparam int ADDRW      = $clog2(H_SCALED * V_SCALED),
   localparam int BANKW      = $clog2(N_BANKS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr_valid,
   input  logic [DATA_W-1:0]         wr_data,
   output logic                      wr_ready,
   input  logic                      frame_start,
   input  logic [X_ADDRW-1:0]        vga_x,
   input  logic [Y_ADDRW-1:0]        vga_y,
   output logic [N_BANKS-1:0]        bank_we,
   output logic [ADDRW-1:0]          wr_addr,
   output logic [ADDRW-1:0]          rd_addr,
   input  logic [N_BANKS*DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0]         pixel_color,
   output logic [BANKW-1:0]          disp_bank,
   output logic [7:0]                drop_cnt,
   output logic [7:0]                repeat_cnt
);

   localparam int XW = (H_SCALED > 1) ? $clog2(H_SCALED) : 1;
   localparam int YW = (V_SCALED > 1) ? $clog2(V_SCALED) : 1;

   typedef enum logic [1:0] {B_FREE, B_FILLING, B_READY, B_DISPLAY} bank_state_t;
   typedef enum logic [1:0] {W_SEEK, W_FILL, W_HOLD} wr_state_t;

   bank_state_t       bank_q [N_BANKS];
   bank_state_t       bank_d [N_BANKS];
   wr_state_t         wst_q, wst_d;
   logic [BANKW-1:0]  fill_q, fill_d;
   logic [BANKW-1:0]  disp_q, disp_nx;
   logic [BANKW-1:0]  disp_p1, disp_p2;
   logic [XW-1:0]     wx_q;
   logic [YW-1:0]     wy_q;
   logic [ADDRW-1:0]  waddr_q;
   logic [ADDRW-1:0]  raddr_q;
   logic [DATA_W-1:0] pix_q;
   logic [7:0]        drop_q, rep_q;
   logic              drop_inc, rep_inc;

   logic              free_found, ready_found;
   logic [BANKW-1:0]  free_idx, ready_idx;
   logic              accept, last_px, complete, ready_left;

   assign wr_ready    = (wst_q == W_FILL) && !reset;
   assign accept      = wr_ready && wr_valid;
   assign last_px     = (wx_q == XW'(H_SCALED - 1)) && (wy_q == YW'(V_SCALED - 1));
   assign complete    = accept && last_px;
   // A READY bank consumed by this cycle's frame_start no longer blocks the writer.
   assign ready_left  = ready_found && !frame_start;
   assign bank_we     = accept ? (N_BANKS'(1) << fill_q) : '0;
   assign wr_addr     = waddr_q;
   assign rd_addr     = raddr_q;
   assign pixel_color = pix_q;
   assign disp_bank   = disp_q;
   assign drop_cnt    = drop_q;
   assign repeat_cnt  = rep_q;

   // Locate the lowest-index FREE bank and the (single) READY bank.
   always_comb begin
      free_found  = 1'b0;
      free_idx    = '0;
      ready_found = 1'b0;
      ready_idx   = '0;
      for (int unsigned i = 0; i < N_BANKS; i++) begin
         if (!free_found && bank_q[i] == B_FREE) begin
            free_found = 1'b1;
            free_idx   = BANKW'(i);
         end
         if (bank_q[i] == B_READY) begin
            ready_found = 1'b1;
            ready_idx   = BANKW'(i);
         end
      end
   end

   // Next bank states, writer state and display selection.
   always_comb begin
      bank_d   = bank_q;
      wst_d    = wst_q;
      fill_d   = fill_q;
      disp_nx  = disp_q;
      drop_inc = 1'b0;
      rep_inc  = 1'b0;

      if (frame_start) begin
         if (ready_found) begin
            bank_d[ready_idx] = B_DISPLAY;
            bank_d[disp_q]    = B_FREE;
            disp_nx           = ready_idx;
         end else begin
            rep_inc = 1'b1;
         end
      end

      unique case (wst_q)
         W_SEEK: begin
            if (free_found) begin
               bank_d[free_idx] = B_FILLING;
               fill_d           = free_idx;
               wst_d            = W_FILL;
            end
         end
         W_FILL: begin
            if (complete) begin
               if (!ready_left) begin
                  bank_d[fill_q] = B_READY;
                  wst_d          = W_SEEK;
               end else if (DROP_MODE != 0) begin
                  bank_d[ready_idx] = B_FREE;
                  bank_d[fill_q]    = B_READY;
                  drop_inc          = 1'b1;
                  wst_d             = W_SEEK;
               end else begin
                  wst_d = W_HOLD;
               end
            end
         end
         W_HOLD: begin
            if (!ready_found) begin
               bank_d[fill_q] = B_READY;
               wst_d          = W_SEEK;
            end
         end
         default: wst_d = W_SEEK;
      endcase
   end

   // Bank/writer state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < N_BANKS; i++)
            bank_q[i] <= (i == 0) ? B_DISPLAY : B_FREE;
         wst_q  <= W_SEEK;
         fill_q <= '0;
         disp_q <= '0;
      end else begin
         bank_q <= bank_d;
         wst_q  <= wst_d;
         fill_q <= fill_d;
         disp_q <= disp_nx;
      end
   end

   // Raster write counters; the linear address tracks wy*H_SCALED + wx.
   always_ff @(posedge clk) begin
      if (reset) begin
         wx_q    <= '0;
         wy_q    <= '0;
         waddr_q <= '0;
      end else if (wst_q == W_SEEK && free_found) begin
         wx_q    <= '0;
         wy_q    <= '0;
         waddr_q <= '0;
      end else if (accept) begin
         waddr_q <= waddr_q + 1'b1;
         if (wx_q == XW'(H_SCALED - 1)) begin
            wx_q <= '0;
            wy_q <= wy_q + 1'b1;
         end else begin
            wx_q <= wx_q + 1'b1;
         end
      end
   end

   // Saturating drop / repeat statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         drop_q <= '0;
         rep_q  <= '0;
      end else begin
         if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
         if (rep_inc && rep_q != 8'hFF)   rep_q  <= rep_q + 8'd1;
      end
   end

   // Read pipeline: bank select travels alongside the address so a bank
   // switch can never pick a slice belonging to a different read.
   always_ff @(posedge clk) begin
      if (reset) begin
         raddr_q <= '0;
         disp_p1 <= '0;
         disp_p2 <= '0;
         pix_q   <= '0;
      end else begin
         raddr_q <= ADDRW'(32'(vga_y >> SCALE_SHIFT) * 32'(H_SCALED)
                           + 32'(vga_x >> SCALE_SHIFT));
         disp_p1 <= disp_q;
         disp_p2 <= disp_p1;
         pix_q   <= rd_data[disp_p2 * DATA_W +: DATA_W];
      end
   end

endmodule

// File: tb/tb_frame_bank_ctrl.sv
// Scoreboard bench for frame_bank_ctrl: four parameterisations driven with
// random pixels, vsync pulses, scan positions and a mid-run reset; a
// frame-level reference model queues expected responses, monitors compare.
module tb_frame_bank_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit done [4];

   typedef struct {int due; int a; int b; int c;} ev_t;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input int g, input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL inst%0d %s: got %0d expected %0d at cycle %0d", g, name, got, exp, cyc);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : inst
      localparam int N     = (g == 0) ? 2 : (g == 3) ? 4 : 3;
      localparam int DM    = (g == 1 || g == 3) ? 1 : 0;
      localparam int H     = (g == 0) ? 160 : (g == 3) ? 5 : 8;
      localparam int V     = (g == 0) ? 120 : (g == 3) ? 3 : 4;
      localparam int SS    = (g == 3) ? 1 : 2;
      localparam int DW    = (g == 2) ? 2 : 1;
      localparam int AW    = $clog2(H * V);
      localparam int BW    = $clog2(N);
      localparam int NCYC  = (g == 0) ? 48000 : 20000;
      localparam int FSP   = (g == 0) ? 7000 : (g == 1) ? 200 : (g == 2) ? 40 : 16;
      localparam int VPROB = (g == 0) ? 15 : (g == 3) ? 8 : 12;

      logic          rst, wv, fs, wr_rdy;
      logic [DW-1:0] wd, pc;
      logic [9:0]    vx;
      logic [8:0]    vy;
      logic [N-1:0]  we;
      logic [AW-1:0] wa, ra;
      logic [N*DW-1:0] rdd;
      logic [BW-1:0] db;
      logic [7:0]    dc, rc;

      frame_bank_ctrl #(
         .X_ADDRW(10), .Y_ADDRW(9), .SCALE_SHIFT(SS), .H_SCALED(H), .V_SCALED(V),
         .N_BANKS(N), .DATA_W(DW), .DROP_MODE(DM)
      ) dut (
         .clk(clk), .reset(rst), .wr_valid(wv), .wr_data(wd), .wr_ready(wr_rdy),
         .frame_start(fs), .vga_x(vx), .vga_y(vy), .bank_we(we), .wr_addr(wa),
         .rd_addr(ra), .rd_data(rdd), .pixel_color(pc), .disp_bank(db),
         .drop_cnt(dc), .repeat_cnt(rc)
      );

      // Synchronous bank RAMs (one-cycle read latency) attached to the DUT.
      logic [DW-1:0] ram [N][1 << AW];
      logic [DW-1:0] rq  [N];
      always @(posedge clk) begin
         for (int b = 0; b < N; b++) begin
            if (we[b]) ram[b][wa] <= wd;
            rq[b] <= ram[b][ra];
         end
      end
      always_comb begin
         rdd = '0;
         for (int b = 0; b < N; b++) rdd[b*DW +: DW] = rq[b];
      end

      // Reference model state: which bank shows, which waits, which fills.
      int disp, ready, filling, sel_cyc, npix, drop, rep;
      bit held;
      logic [DW-1:0] mm [N][1 << AW];
      bit            wf [N][1 << AW];
      ev_t wq[$], aq[$], sq[$], pq[$];

      initial begin
         int  rst_at, t, ea, mask, addr, rb, fb, d0;
         bit  r, rdy, acc, cmp, found;
         rst_at = NCYC / 2 + int'($urandom_range(0, 500));
         rst = 1'b1; wv = 1'b0; fs = 1'b0; wd = '0; vx = '0; vy = '0;
         disp = 0; ready = -1; filling = -1; sel_cyc = 0; npix = 0;
         drop = 0; rep = 0; held = 1'b0;
         for (int k = 0; k < NCYC; k++) begin
            @(posedge clk); #1;
            t  = cyc;
            r  = (k < 3) || (k >= rst_at && k < rst_at + 3);
            rst = r;
            wv = ($urandom_range(0, 15) < VPROB);
            fs = ($urandom_range(0, FSP - 1) == 0);
            wd = DW'($urandom);
            vx = 10'($urandom_range(0, (H << SS) + 3));
            vy = 9'($urandom_range(0, (V << SS) + 3));
            if (r) begin
               disp = 0; ready = -1; filling = -1; held = 1'b0; npix = 0;
               drop = 0; rep = 0;
               wq.push_back('{t, 0, 0, 0});
               aq.push_back('{t + 1, 0, 0, 0});
               while (pq.size() > 0 && pq[$].due >= t + 1) void'(pq.pop_back());
               pq.push_back('{t + 1, 0, 0, 0});
               sq.push_back('{t + 1, 0, 0, 0});
            end else begin
               rdy  = (filling >= 0) && !held && (t > sel_cyc);
               acc  = wv && rdy;
               mask = 0; addr = 0;
               cmp  = acc && (npix == H * V - 1);
               if (acc) begin
                  mask = 1 << filling;
                  addr = npix;
                  mm[filling][npix] = wd;
                  wf[filling][npix] = 1'b1;
                  npix++;
               end
               wq.push_back('{t, int'(rdy), mask, addr});
               ea = ((int'(vy) >> SS) * H + (int'(vx) >> SS)) % (1 << AW);
               aq.push_back('{t + 1, ea, 0, 0});
               if (wf[disp][ea]) pq.push_back('{t + 3, int'(mm[disp][ea]), 0, 0});
               rb = ready; fb = filling; d0 = disp;
               if (fs) begin
                  if (rb >= 0) begin disp = rb; ready = -1; end
                  else rep = (rep < 255) ? rep + 1 : 255;
               end
               if (cmp) begin
                  if (rb < 0 || fs) begin ready = fb; filling = -1; end
                  else if (DM != 0) begin
                     ready = fb; filling = -1;
                     drop = (drop < 255) ? drop + 1 : 255;
                  end else held = 1'b1;
               end else if (held && rb < 0) begin
                  ready = fb; filling = -1; held = 1'b0;
               end else if (fb < 0) begin
                  found = 1'b0;
                  for (int b = 0; b < N; b++) begin
                     if (!found && b != d0 && b != rb) begin
                        found = 1'b1; filling = b; sel_cyc = t; npix = 0;
                     end
                  end
               end
               sq.push_back('{t + 1, disp, drop, rep});
            end
         end
         done[g] = 1'b1;
      end

      initial begin
         ev_t e;
         forever begin
            @(negedge clk);
            if (done[g]) break;
            if (wq.size() > 0 && wq[0].due == cyc) begin
               e = wq.pop_front();
               check(g, "wr_ready", int'(wr_rdy), e.a);
               check(g, "bank_we", int'(we), e.b);
               if (e.b != 0) check(g, "wr_addr", int'(wa), e.c);
            end
            if (aq.size() > 0 && aq[0].due == cyc) begin
               e = aq.pop_front();
               check(g, "rd_addr", int'(ra), e.a);
            end
            if (sq.size() > 0 && sq[0].due == cyc) begin
               e = sq.pop_front();
               check(g, "disp_bank", int'(db), e.a);
               check(g, "drop_cnt", int'(dc), e.b);
               check(g, "repeat_cnt", int'(rc), e.c);
            end
            if (pq.size() > 0 && pq[0].due == cyc) begin
               e = pq.pop_front();
               check(g, "pixel_color", int'(pc), e.a);
            end
         end
      end
   end

   initial begin
      int k;
      k = 0;
      while (!(done[0] && done[1] && done[2] && done[3]) && k < 60000) begin
         @(posedge clk);
         k++;
      end
      if (!(done[0] && done[1] && done[2] && done[3])) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: stimulus incomplete after %0d cycles, required completion", k);
      end
      #20;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
